pu_pool_unit: RTL
=================

# pu_pool_unit

Streaming 2x2/stride-2 max-pool stage that sits directly downstream of the PE array and is sequenced by the PU controller's pooling counters. It consumes one pixel per accepted beat from NUM_PE lanes, where each lane is an independent output channel. In pooling mode it emits one pooled pixel per 2x2 window; in bypass mode it passes data through with one register stage. It returns `pool_ready` to the controller's stride/pool_iw counters and flags frame completion.

## Interface
- NUM_PE, 4, lanes (output channels) processed in parallel
- DATA_WIDTH, 16, signed two's-complement pixel width per lane
- LAYER_PARAM_WIDTH, 10, width of frame dimension config
- MAX_IW, 512, maximum input row width; row buffer depth is MAX_IW/2

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; latches config, clears counters, enters RUN
- cfg_pool_enable  in  1  1 = 2x2 max-pool, 0 = bypass
- cfg_iw  in  LAYER_PARAM_WIDTH  input row width minus 1
- cfg_ih  in  LAYER_PARAM_WIDTH  input row count minus 1
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_data  in  NUM_PE*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  NUM_PE*DATA_WIDTH  pooled/bypassed pixels
- pool_ready  out  1  high in the cycle an output beat transfers (out_valid && out_ready)
- frame_done  out  1  one-cycle pulse after the last input beat of the frame is accepted
- busy  out  1  state == RUN

## Operation
- States: IDLE (0), RUN (1). IDLE -> RUN on start. RUN -> IDLE when the last input beat (col == cfg_iw, row == cfg_ih) is accepted. start in RUN restarts: config is relatched, col/row are cleared, any pending out_valid is dropped, and the state stays RUN.
- In IDLE, in_ready = 0. In RUN, in_ready = !out_valid || out_ready.
- Beat accept = in_valid && in_ready. Counters col (0..cfg_iw) and row (0..cfg_ih) advance on accept only. col wraps to 0 and row increments when col == cfg_iw.
- Bypass: every accepted beat is registered to out_data, with out_valid set the next cycle.
- Pool, per lane, signed compare:
  - Even col: hold the pixel in h_reg.
  - Odd col: hmax = max(h_reg, in).
  - Even row, odd col: write hmax to rowbuf[col>>1].
  - Odd row, odd col: out = max(rowbuf[col>>1], hmax), and out_valid is set.
- Odd dimensions use floor semantics. If cfg_iw is even (odd width), the last column of each row is dropped. If cfg_ih is even (odd height), the last row is accepted but produces no output and no rowbuf write is consumed.
- Ties resolve to the equal value; there is no rounding. Output width equals input width.
- The output register holds its value while out_valid && !out_ready. out_valid clears on transfer unless a new result is loaded in the same cycle.
- frame_done fires even if the final output is still pending. The final out beat remains valid until it transfers.

## Timing
- Reset values: state = IDLE, in_ready = 0, out_valid = 0, out_data = 0, pool_ready = 0, frame_done = 0, busy = 0, col = row = 0. rowbuf contents are don't-care.
- Bypass latency: accept in cycle N -> out_valid in N+1.
- Pool latency: accept of the odd-row/odd-col pixel in cycle N -> out_valid in N+1.
- The rowbuf read is combinational from the registered address or completes within the same cycle. No extra bubble is allowed, so full throughput is 1 beat/cycle with out_ready held high.
- frame_done asserts in the cycle after the final accept. busy drops in that same cycle.
- Config inputs are sampled only on the start cycle.

## Test plan
- Bypass, iw = ih = 4 (cfg = 3), 16 beats with values 0..15 and out_ready = 1 -> 16 outputs equal to the inputs, each 1 cycle later; frame_done one cycle after beat 15.
- Pool 4x4, lane0 rows [1,2,3,4], [5,6,7,8], [9,10,11,12], [13,14,15,16] -> outputs 6, 8, 14, 16; pool_ready pulses 4 times.
- Pool 5x5 (cfg_iw = cfg_ih = 4), ramp input -> exactly 4 outputs; column 4 and row 4 are ignored; frame_done after the 25th accept.
- Negative values: lane1 window {-3, -7, -1, -9} -> -1. Ties {5, 5, 5, 5} -> 5.
- Backpressure: hold out_ready = 0 for 5 cycles while an output is pending -> in_ready = 0, out_data stable, no beats lost; on release the sequence matches the free-running run.
- start pulsed mid-frame after 6 beats with new cfg -> pending output dropped, counters reset; the next frame matches expected results for the new cfg.

Source files
------------

// File: rtl/pu_pool_unit.sv
// Streaming 2x2/stride-2 max-pool stage (or one-register bypass) for NUM_PE parallel lanes.
// Even rows leave horizontal maxima in a half-width row buffer; odd rows merge them and emit a pixel.
module pu_pool_unit #(
  parameter int NUM_PE            = 4,
  parameter int DATA_WIDTH        = 16,
  parameter int LAYER_PARAM_WIDTH = 10,
  parameter int MAX_IW            = 512
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           cfg_pool_enable,
  input  logic [LAYER_PARAM_WIDTH-1:0]   cfg_iw,
  input  logic [LAYER_PARAM_WIDTH-1:0]   cfg_ih,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_PE*DATA_WIDTH-1:0]   in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_PE*DATA_WIDTH-1:0]   out_data,
  output logic                           pool_ready,
  output logic                           frame_done,
  output logic                           busy
);

  localparam int BW        = NUM_PE * DATA_WIDTH;
  localparam int BUF_DEPTH = MAX_IW / 2;
  localparam int AW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                       state_q, state_d;
  logic [LAYER_PARAM_WIDTH-1:0] col_q, col_d;
  logic [LAYER_PARAM_WIDTH-1:0] row_q, row_d;
  logic [LAYER_PARAM_WIDTH-1:0] iw_q, iw_d;
  logic [LAYER_PARAM_WIDTH-1:0] ih_q, ih_d;
  logic                         pool_en_q, pool_en_d;
  logic [BW-1:0]                h_q, h_d;
  logic                         out_valid_q, out_valid_d;
  logic [BW-1:0]                out_data_q, out_data_d;
  logic                         frame_done_q, frame_done_d;

  logic [BW-1:0]                rowbuf [BUF_DEPTH];
  logic [BW-1:0]                buf_rd_q;
  logic [AW-1:0]                buf_addr;
  logic                         buf_we, buf_re;
  logic [BW-1:0]                hmax, pooled;
  logic                         accept, last_col, last_row;

  assign in_ready   = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign last_col   = (col_q == iw_q);
  assign last_row   = (row_q == ih_q);
  assign buf_addr   = AW'(col_q >> 1);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign pool_ready = out_valid_q && out_ready;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == RUN);

  generate
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_lane
      logic signed [DATA_WIDTH-1:0] h_l, in_l, rd_l, hmax_l;
      assign h_l    = h_q[gi*DATA_WIDTH +: DATA_WIDTH];
      assign in_l   = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign rd_l   = buf_rd_q[gi*DATA_WIDTH +: DATA_WIDTH];
      assign hmax_l = (in_l > h_l) ? in_l : h_l;
      assign hmax[gi*DATA_WIDTH +: DATA_WIDTH]   = hmax_l;
      assign pooled[gi*DATA_WIDTH +: DATA_WIDTH] = (rd_l > hmax_l) ? rd_l : hmax_l;
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    iw_d         = iw_q;
    ih_d         = ih_q;
    pool_en_d    = pool_en_q;
    h_d          = h_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    buf_we       = 1'b0;
    buf_re       = 1'b0;

    if (start) begin
      // A restart discards the current frame, including any undelivered output.
      state_d     = RUN;
      iw_d        = cfg_iw;
      ih_d        = cfg_ih;
      pool_en_d   = cfg_pool_enable;
      col_d       = '0;
      row_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (accept) begin
        if (last_col) begin
          col_d = '0;
          row_d = last_row ? '0 : row_q + 1'b1;
          if (last_row) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end

        if (!pool_en_q) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data;
        end else if (!col_q[0]) begin
          h_d    = in_data;
          // Prefetch the partner row's maximum so the odd-column beat sees it without a bubble.
          buf_re = row_q[0];
        end else if (!row_q[0]) begin
          buf_we = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = pooled;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) rowbuf[buf_addr] <= hmax;
    if (buf_re) buf_rd_q <= rowbuf[buf_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      iw_q         <= '0;
      ih_q         <= '0;
      pool_en_q    <= 1'b0;
      h_q          <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      iw_q         <= iw_d;
      ih_q         <= ih_d;
      pool_en_q    <= pool_en_d;
      h_q          <= h_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
